moving_avg_filter_mc: RTL

Multi-channel, runtime-configurable successor to the single-channel moving average filter. It computes y(n) = (1/2^w) * SUM over the last 2^w samples x(n) independently for up to NUM_CH time-multiplexed channels. The window exponent w is selectable at run time up to a synthesis-time maximum, and rounding is optional. It sits after the channelised sample source and feeds downstream per-channel consumers using the same valid-qualified sample bus, extended with a channel tag.

---
 rtl/moving_avg_filter_mc.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/moving_avg_filter_mc.sv
// moving_avg_filter_mc
// Multi-channel moving average over the last 2^w samples of each channel.
// Channels share one history RAM addressed {ch, ptr}. Pointer and fill state
// update in the accept cycle. The accumulator and output update one cycle
// later. This lets back-to-back samples on one channel flow without a stall.
module moving_avg_filter_mc #(
  parameter int DATA_WIDTH     = 16,
  parameter int MAX_WIND_WIDTH = 5,
  parameter int NUM_CH         = 4,
  localparam int CH_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WSEL_WIDTH    = $clog2(MAX_WIND_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [WSEL_WIDTH-1:0] wind_sel,
  input  logic                  round_en,
  input  logic [DATA_WIDTH-1:0] x_N,
  input  logic [CH_WIDTH-1:0]   x_N_ch,
  input  logic                  x_N_valid,
  output logic [DATA_WIDTH-1:0] y_N,
  output logic [CH_WIDTH-1:0]   y_N_ch,
  output logic                  y_N_valid
);

  localparam int DEPTH      = 2 ** MAX_WIND_WIDTH;
  localparam int ACC_WIDTH  = DATA_WIDTH + MAX_WIND_WIDTH;
  localparam int SUM_WIDTH  = ACC_WIDTH + 1;
  localparam int FILL_WIDTH = MAX_WIND_WIDTH + 1;
  localparam int ADDR_WIDTH = CH_WIDTH + MAX_WIND_WIDTH;

  // reset and flush have identical effect on every piece of state
  logic clear;
  assign clear = reset | flush;

  // ---------------------------------------------------------------------------
  // Configuration captured at reset/flush time
  // ---------------------------------------------------------------------------
  logic [WSEL_WIDTH-1:0] w_q;
  logic                  round_q;
  logic [FILL_WIDTH-1:0] win_len;

  // latch window exponent (clamped) and rounding mode whenever state is cleared
  always_ff @(posedge clk) begin
    if (clear) begin
      w_q     <= (wind_sel > WSEL_WIDTH'(MAX_WIND_WIDTH)) ? WSEL_WIDTH'(MAX_WIND_WIDTH) : wind_sel;
      round_q <= round_en;
    end
  end

  assign win_len = FILL_WIDTH'(1) << w_q;

  // ---------------------------------------------------------------------------
  // Accept stage: channel lookup, pointer/fill update, RAM access
  // ---------------------------------------------------------------------------
  logic ch_in_range;

  generate
    if (NUM_CH == (1 << CH_WIDTH)) begin : g_full_range
      assign ch_in_range = 1'b1;
    end else begin : g_part_range
      assign ch_in_range = (x_N_ch < CH_WIDTH'(NUM_CH));
    end
  endgenerate

  logic accept;
  assign accept = x_N_valid & ch_in_range & ~clear;

  logic [MAX_WIND_WIDTH-1:0] wr_ptr [NUM_CH];
  logic [FILL_WIDTH-1:0]     fill   [NUM_CH];

  logic [MAX_WIND_WIDTH-1:0] cur_ptr;
  logic [MAX_WIND_WIDTH-1:0] rd_ptr;
  logic [FILL_WIDTH-1:0]     cur_fill;
  logic [FILL_WIDTH-1:0]     fill_next;
  logic                      full_before;
  logic                      full_after;
  logic [ADDR_WIDTH-1:0]     wr_addr;
  logic [ADDR_WIDTH-1:0]     rd_addr;

  assign cur_ptr     = wr_ptr[x_N_ch];
  assign cur_fill    = fill[x_N_ch];
  assign full_before = (cur_fill == win_len);
  assign fill_next   = full_before ? cur_fill : cur_fill + 1'b1;
  assign full_after  = (fill_next == win_len);
  // the sample leaving the window sits 2^w slots behind the write pointer;
  // at w = MAX_WIND_WIDTH this wraps onto the write address itself
  assign rd_ptr      = cur_ptr - win_len[MAX_WIND_WIDTH-1:0];
  assign wr_addr     = {x_N_ch, cur_ptr};
  assign rd_addr     = {x_N_ch, rd_ptr};

  // advance the channel's write pointer and saturating fill count on accept
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        fill[i]   <= '0;
      end
    end else if (accept) begin
      wr_ptr[x_N_ch] <= cur_ptr + 1'b1;
      fill[x_N_ch]   <= fill_next;
    end
  end

  // ---------------------------------------------------------------------------
  // History RAM: simple dual port, registered read-first read port
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [NUM_CH * DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;

  // write the new sample and fetch the outgoing one; the read sees the old word
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_data      <= mem[rd_addr];
      mem[wr_addr] <= x_N;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic                  s1_valid;
  logic [CH_WIDTH-1:0]   s1_ch;
  logic [DATA_WIDTH-1:0] s1_x;
  logic                  s1_full_before;
  logic                  s1_full_after;

  // carry the accepted sample and its window state alongside the RAM read
  always_ff @(posedge clk) begin
    if (clear) begin
      s1_valid       <= 1'b0;
      s1_ch          <= '0;
      s1_x           <= '0;
      s1_full_before <= 1'b0;
      s1_full_after  <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ch          <= x_N_ch;
        s1_x           <= x_N;
        s1_full_before <= full_before;
        s1_full_after  <= full_after;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: accumulate, round, scale
  // ---------------------------------------------------------------------------
  logic [ACC_WIDTH-1:0]  acc [NUM_CH];
  logic [DATA_WIDTH-1:0] x_old;
  logic [ACC_WIDTH-1:0]  acc_new;
  logic [SUM_WIDTH-1:0]  round_add;
  logic [SUM_WIDTH-1:0]  sum_rnd;
  logic [SUM_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0] y_next;
  logic                  emit;

  // until the window has filled, nothing is leaving it, so subtract zero
  assign x_old     = s1_full_before ? rd_data : '0;
  assign acc_new   = acc[s1_ch] + ACC_WIDTH'(s1_x) - ACC_WIDTH'(x_old);
  assign round_add = (round_q && (w_q != '0)) ? (SUM_WIDTH'(1) << (w_q - 1'b1)) : '0;
  assign sum_rnd   = {1'b0, acc_new} + round_add;
  assign shifted   = sum_rnd >> w_q;
  assign y_next    = (|shifted[SUM_WIDTH-1:DATA_WIDTH]) ? '1 : shifted[DATA_WIDTH-1:0];
  assign emit      = s1_valid & s1_full_after;

  // commit the running sum of the channel that was in stage 1
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
      end
    end else if (s1_valid) begin
      acc[s1_ch] <= acc_new;
    end
  end

  // register the average only once the channel's window is full
  always_ff @(posedge clk) begin
    if (clear) begin
      y_N       <= '0;
      y_N_ch    <= '0;
      y_N_valid <= 1'b0;
    end else begin
      y_N_valid <= emit;
      if (emit) begin
        y_N    <= y_next;
        y_N_ch <= s1_ch;
      end
    end
  end

endmodule
